// File: rtl/nn_eval_pkg.sv
// Shared definitions for the NN core, argmax_compare and evaluate stages.
// Holds the default sizing constants, the score type and the compare FSM states.
package nn_eval_pkg;

    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 16;
    localparam int IDX_W     = 4;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic {ACCUM, RESULT} cmp_state_t;

endpackage

// File: rtl/argmax_compare.sv
// Serial argmax over one sample's output-layer scores, compared against the sample's label.
// Emits one held result beat (pred_class, mismatch) per sample and a sticky framing-error flag.
module argmax_compare
    import nn_eval_pkg::cmp_state_t;
    import nn_eval_pkg::ACCUM;
    import nn_eval_pkg::RESULT;
#(
    parameter int N_CLASSES = nn_eval_pkg::N_CLASSES,
    parameter int SCORE_W   = nn_eval_pkg::SCORE_W,
    parameter int IDX_W     = nn_eval_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score_data,
    input  logic                      score_last,
    input  logic [IDX_W-1:0]          label,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [IDX_W-1:0]          pred_class,
    output logic                      mismatch,
    output logic                      proto_err,
    output logic                      state_dbg
);

    // Handshakes: a beat moves on a rising edge where valid && ready are both high;
    // valid/data stay stable while ready is low, and ready never waits on valid.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
    localparam logic [IDX_W:0]   N_CLS    = (IDX_W + 1)'(N_CLASSES);

    cmp_state_t                state;
    logic [IDX_W-1:0]          idx;
    logic signed [SCORE_W-1:0] max_val;
    logic [IDX_W-1:0]          max_idx;
    logic [IDX_W-1:0]          label_q;

    logic             accept;
    logic             first;
    logic             last_slot;
    logic             update;
    logic             end_beat;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] cur_label;

    assign score_ready = (state == ACCUM) && !reset;
    assign state_dbg   = state;

    always_comb begin
        accept    = score_valid && score_ready;
        first     = (idx == '0);
        last_slot = (idx == LAST_IDX);
        // Strict compare: on a tie the earlier class keeps the win.
        update    = first || (score_data > max_val);
        cand_idx  = update ? idx : max_idx;
        // A sample can end on its first beat, before label_q has been loaded.
        cur_label = first ? label : label_q;
        end_beat  = score_last || last_slot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            idx          <= '0;
            max_val      <= '0;
            max_idx      <= '0;
            label_q      <= '0;
            result_valid <= 1'b0;
            pred_class   <= '0;
            mismatch     <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (update) begin
                            max_val <= score_data;
                            max_idx <= cand_idx;
                        end
                        if (first) begin
                            label_q <= label;
                        end
                        if (end_beat) begin
                            pred_class   <= cand_idx;
                            mismatch     <= ({1'b0, cur_label} >= N_CLS) || (cand_idx != cur_label);
                            // score_last must coincide exactly with the final class slot.
                            if (score_last != last_slot) begin
                                proto_err <= 1'b1;
                            end
                            idx          <= '0;
                            result_valid <= 1'b1;
                            state        <= RESULT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_compare.sv
// Bench for argmax_compare: directed vector table, hand-written multi-cycle sequences,
// and random samples checked against an argmax reference model.
module tb_argmax_compare;

    localparam int N  = 10;
    localparam int SW = 16;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 score_valid;
    logic                 score_ready;
    logic signed [SW-1:0] score_data;
    logic                 score_last;
    logic [IW-1:0]        label;
    logic                 result_valid;
    logic                 result_ready;
    logic [IW-1:0]        pred_class;
    logic                 mismatch;
    logic                 proto_err;
    logic                 state_dbg;

    int total = 0;
    int bad   = 0;
    logic [IW-1:0] exp_q[$];

    argmax_compare #(.N_CLASSES(N), .SCORE_W(SW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_last(score_last), .label(label),
        .result_valid(result_valid), .result_ready(result_ready),
        .pred_class(pred_class), .mismatch(mismatch), .proto_err(proto_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][SW-1:0] s;
        int lbl;
        int last_pos;   // beat carrying score_last, -1 for none
        int exp_pred;
        int exp_mm;
        int exp_pe;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(int a0, int a1, int a2, int a3, int a4, int a5, int a6,
                                int a7, int a8, int a9, int lbl, int lp, int ep, int em, int epe);
        vec_t v;
        v.s[0] = SW'(a0); v.s[1] = SW'(a1); v.s[2] = SW'(a2); v.s[3] = SW'(a3);
        v.s[4] = SW'(a4); v.s[5] = SW'(a5); v.s[6] = SW'(a6); v.s[7] = SW'(a7);
        v.s[8] = SW'(a8); v.s[9] = SW'(a9);
        v.lbl = lbl; v.last_pos = lp; v.exp_pred = ep; v.exp_mm = em; v.exp_pe = epe;
        return v;
    endfunction

    // Reference: first index of the largest signed score among the first n beats.
    function automatic int ref_argmax(logic [N-1:0][SW-1:0] s, int n);
        int best = 0;
        for (int i = 1; i < n; i++) begin
            if ($signed(s[i]) > $signed(s[best])) best = i;
        end
        return best;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int cycles);
        reset = 1'b1;
        score_valid = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("ready_in_reset", score_ready, 0);
        end
        reset = 1'b0;
        tick();
    endtask

    // Drives one sample; returns at #1 after the edge that accepted its final beat.
    task automatic send_sample(logic [N-1:0][SW-1:0] s, int lbl, int last_pos, int gap_pct);
        int nb = (last_pos >= 0) ? last_pos + 1 : N;
        for (int i = 0; i < nb; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                score_valid = 1'b0;
                tick();
            end
            score_valid = 1'b1;
            score_data  = s[i];
            score_last  = (i == last_pos);
            label       = (i == 0) ? IW'(lbl) : IW'($urandom_range(15));
            if (!score_ready) chk("ready_for_beat", score_ready, 1);
            tick();
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    // Checks the held result, optionally stalls it, then consumes it.
    task automatic take_result(string tag, int ep, int em, int epe, int hold);
        int waited = 0;
        while (!result_valid && waited < 50) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_pred"}, pred_class, ep);
        chk({tag, "_mismatch"}, mismatch, em);
        chk({tag, "_proto_err"}, proto_err, epe);
        for (int i = 0; i < hold; i++) tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_valid_drop"}, result_valid, 0);
    endtask

    initial begin
        logic [N-1:0][SW-1:0] rs;
        int exp_pe;
        logic [IW-1:0] hp;
        logic hm;

        score_data = '0; score_last = 1'b0; label = '0;
        vecs[0] = mk(3, -7, 12, 5, 0, 1, 2, -1, 9, 4, 2, 9, 2, 0, 0);
        vecs[1] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32767, -32768, -32768, -32768,
                     3, 9, 6, 1, 0);
        vecs[2] = mk(0, 0, 0, 0, 100, 0, 0, 100, 0, 0, 4, 9, 4, 0, 0);
        vecs[3] = mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 9, 9, 1, 0);
        vecs[4] = mk(10, -3, 20, -4, 20, 99, 99, 99, 99, 99, 2, 4, 2, 0, 1);
        vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 7, 9, 7, 0, 1);
        vecs[6] = mk(5, 4, 3, 2, 1, 0, -1, -2, -3, -4, 0, -1, 0, 0, 1);
        vecs[7] = mk(-5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);

        do_reset(3);
        chk("rst_score_ready", score_ready, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_pred", pred_class, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_proto_err", proto_err, 0);

        for (int v = 0; v < 8; v++) begin
            send_sample(vecs[v].s, vecs[v].lbl, vecs[v].last_pos, 0);
            chk($sformatf("vec%0d_latency", v), result_valid, 1);
            take_result($sformatf("vec%0d", v), vecs[v].exp_pred, vecs[v].exp_mm, vecs[v].exp_pe, 0);
        end

        do_reset(2);
        chk("perr_cleared", proto_err, 0);

        // Backpressure: result held for 20 cycles while score_valid pulses.
        send_sample(vecs[0].s, 2, 9, 0);
        for (int i = 0; i < 20; i++) begin
            score_valid = i[0];
            score_data  = 16'sh7fff;
            chk("bp_score_ready", score_ready, 0);
            tick();
            chk("bp_valid", result_valid, 1);
            chk("bp_pred", pred_class, 2);
            chk("bp_mismatch", mismatch, 0);
        end
        score_valid = 1'b0;
        take_result("bp_release", 2, 0, 0, 0);
        send_sample(vecs[2].s, 4, 9, 0);
        take_result("bp_next", 4, 0, 0, 0);

        // Reset partway through a sample discards it.
        for (int i = 0; i < 6; i++) begin
            score_valid = 1'b1; score_data = 16'sd1000; score_last = 1'b0; label = 4'd1;
            tick();
        end
        score_valid = 1'b0;
        do_reset(2);
        chk("abort_no_result", result_valid, 0);
        chk("abort_pred", pred_class, 0);
        send_sample(mk(0, 0, 0, 0, 0, 0, 0, 0, 50, 0, 8, 9, 8, 0, 0).s, 8, 9, 0);
        take_result("post_abort", 8, 0, 0, 0);

        // Random samples with 30% valid gaps and random result stalls.
        exp_pe = 0;
        for (int n = 0; n < 500; n++) begin
            int lbl, lp, nb, ep;
            bit em;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1)) rs[i] = SW'(int'($urandom_range(7)) - 4);
                else rs[i] = SW'($urandom);
            end
            lbl = int'($urandom_range(15));
            case ($urandom_range(9))
                0: lp = int'($urandom_range(8));
                1: lp = -1;
                default: lp = 9;
            endcase
            nb = (lp >= 0) ? lp + 1 : N;
            ep = ref_argmax(rs, nb);
            em = (lbl >= N) || (ep != lbl);
            if (lp != N - 1) exp_pe = 1;
            exp_q.push_back(IW'(ep));
            send_sample(rs, lbl, lp, 30);
            hp = exp_q.pop_front();
            hm = em;
            take_result("rand", int'(hp), int'(hm), exp_pe, int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
